// File: rtl/nov_pkg.sv
// Shared definitions for the non-overlapping N-phase clock generator:
// the sequencer state encoding and the legal phase-count range.
package nov_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } nov_state_e;

    // Supported range of phase outputs for a build.
    localparam int NPH_MIN = 2;
    localparam int NPH_MAX = 8;

    // Smallest legal nsel: a frame always has at least two phases.
    localparam logic [2:0] NSEL_MIN = 3'd1;

endpackage

// File: rtl/nov_cnt.sv
// Loadable down-counter with a registered done flag. It is loaded with
// (duration - 1) on entry to a timed state, so done rises on the last
// cycle of that state and the sequencer leaves on the following edge.
module nov_cnt #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          done
);

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] cnt_r;
    logic          done_r;

    // Count register: load wins over decrement, counting stops at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= '0;
            done_r <= 1'b1;
        end else if (load) begin
            cnt_r  <= load_val;
            done_r <= (load_val == '0);
        end else if (dec && !done_r) begin
            cnt_r  <= cnt_r - CNT_ONE;
            done_r <= (cnt_r == CNT_ONE);
        end else begin
            cnt_r  <= cnt_r;
            done_r <= done_r;
        end
    end

    assign done = done_r;

endmodule

// File: rtl/nov_nph_gen.sv
// Non-overlapping N-phase clock generator. Phases 0..nsel fire in turn,
// each high for tph cycles and separated by tnov all-zero cycles. The
// configuration is sampled at start and again only at each frame wrap, so
// mid-frame input changes take effect at the next sof.
module nov_nph_gen #(
    parameter int NPH = 4,
    parameter int CW  = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [CW-1:0]  tph,
    input  logic [CW-1:0]  tnov,
    input  logic [2:0]     nsel,
    output logic [NPH-1:0] ph,
    output logic [NPH-1:0] phb,
    output logic           sof,
    output logic           busy,
    output logic           cfg_err
);

    import nov_pkg::*;

    localparam logic [2:0]    NSEL_MAX = 3'(NPH - 1);
    localparam bit            NPH_OK   = (NPH >= NPH_MIN) && (NPH <= NPH_MAX);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    // A configuration is usable only with non-zero times and a phase
    // count the build actually has outputs for.
    function automatic logic cfg_legal(input logic [CW-1:0] t_h,
                                       input logic [CW-1:0] t_g,
                                       input logic [2:0]    n_s);
        return NPH_OK && (t_h != '0) && (t_g != '0) &&
               (n_s >= NSEL_MIN) && (n_s <= NSEL_MAX);
    endfunction

    // One-hot phase vector for phase index i.
    function automatic logic [NPH-1:0] onehot(input logic [2:0] i);
        return {{(NPH-1){1'b0}}, 1'b1} << i;
    endfunction

    nov_state_e    state_r, state_s;
    logic [2:0]    idx_r, idx_s;
    logic [CW-1:0] tph_r, tnov_r;
    logic [2:0]    nsel_r;
    logic          stop_r, stop_s;
    logic [NPH-1:0] ph_r, phb_r, ph_s;
    logic          sof_r, sof_s;
    logic          busy_r;
    logic          cfg_err_r, cfg_err_s;
    logic          latch_s;
    logic          cnt_load_s, cnt_dec_s, cnt_done_s;
    logic [CW-1:0] cnt_val_s;

    // Shared duration counter for both HIGH and GAP periods.
    nov_cnt #(.CW(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_s),
        .load_val (cnt_val_s),
        .dec      (cnt_dec_s),
        .done     (cnt_done_s)
    );

    // Next-state logic: sequencing, config latching, stop request, errors.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        stop_s     = stop_r;
        sof_s      = 1'b0;
        cfg_err_s  = cfg_err_r;
        latch_s    = 1'b0;
        cnt_load_s = 1'b0;
        cnt_dec_s  = 1'b0;
        cnt_val_s  = '0;
        case (state_r)
            IDLE: begin
                stop_s = 1'b0;
                if (en) begin
                    if (cfg_legal(tph, tnov, nsel)) begin
                        state_s    = HIGH;
                        idx_s      = 3'd0;
                        latch_s    = 1'b1;
                        cnt_load_s = 1'b1;
                        cnt_val_s  = tph - CNT_ONE;
                        sof_s      = 1'b1;
                    end else begin
                        cfg_err_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            HIGH: begin
                // A stop request is remembered so the pulse and its gap finish.
                stop_s = stop_r | ~en;
                if (cnt_done_s) begin
                    state_s    = GAP;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = tnov_r - CNT_ONE;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            GAP: begin
                if (cnt_done_s) begin
                    if (stop_r || !en) begin
                        state_s = IDLE;
                        idx_s   = 3'd0;
                        stop_s  = 1'b0;
                    end else if (idx_r == nsel_r) begin
                        // Frame wrap: the only point where new settings are taken.
                        if (cfg_legal(tph, tnov, nsel)) begin
                            state_s    = HIGH;
                            idx_s      = 3'd0;
                            latch_s    = 1'b1;
                            cnt_load_s = 1'b1;
                            cnt_val_s  = tph - CNT_ONE;
                            sof_s      = 1'b1;
                        end else begin
                            state_s   = IDLE;
                            idx_s     = 3'd0;
                            stop_s    = 1'b0;
                            cfg_err_s = 1'b1;
                        end
                    end else begin
                        state_s    = HIGH;
                        idx_s      = idx_r + 3'd1;
                        cnt_load_s = 1'b1;
                        cnt_val_s  = tph_r - CNT_ONE;
                    end
                end else begin
                    cnt_dec_s = 1'b1;
                    stop_s    = stop_r | ~en;
                end
            end
            default: begin
                state_s = IDLE;
                idx_s   = 3'd0;
                stop_s  = 1'b0;
            end
        endcase
    end

    // Phase vector for the coming cycle: one bit only while in HIGH.
    always_comb begin
        if (state_s == HIGH) begin
            ph_s = onehot(idx_s);
        end else begin
            ph_s = '0;
        end
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            idx_r     <= 3'd0;
            tph_r     <= '0;
            tnov_r    <= '0;
            nsel_r    <= 3'd0;
            stop_r    <= 1'b0;
            ph_r      <= '0;
            phb_r     <= '1;
            sof_r     <= 1'b0;
            busy_r    <= 1'b0;
            cfg_err_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            stop_r    <= stop_s;
            ph_r      <= ph_s;
            phb_r     <= ~ph_s;
            sof_r     <= sof_s;
            busy_r    <= (state_s != IDLE);
            cfg_err_r <= cfg_err_s;
            if (latch_s) begin
                tph_r  <= tph;
                tnov_r <= tnov;
                nsel_r <= nsel;
            end
        end
    end

    assign ph      = ph_r;
    assign phb     = phb_r;
    assign sof     = sof_r;
    assign busy    = busy_r;
    assign cfg_err = cfg_err_r;

endmodule
